// File: rtl/coreaxi4dma_arb_pkg.sv
// Shared definitions for the DMA arbiter and its requester/executor.
//   arb_state_e   : requester FSM encoding (IDLE/RUN/ACK)
//   clog2         : ceiling log2, used for channel-index widths
//   is_onehot     : grant-vector sanity check (exactly one bit set)
//   onehot_encode : index of the set bit in a one-hot vector
// Vectors are passed zero-extended to 32 bits, so channel counts up to 32 are supported.
package coreaxi4dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    ACK  = 2'b10
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic int onehot_encode(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/coreaxi4dma_pend_ctr.sv
// Per-channel pending-job counter.
//   clock, resetn : clock and asynchronous active-low reset
//   inc           : add one job (caller has already applied the full-drop rule)
//   dec           : remove one job (accepted grant)
//   cnt           : current pending count
//   nz            : cnt != 0 (drives the arbiter request)
//   full          : cnt at its maximum value
module coreaxi4dma_pend_ctr #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             full
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && nz) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign nz   = |cnt;
  assign full = &cnt;

endmodule

// File: rtl/coreaxi4dma_arb_requester.sv
// Requester/executor side of the DMA round-robin arbiter.
//   clock, resetn : clock and asynchronous active-low reset
//   enq/len       : per-channel job enqueue pulse and job length (beats-1)
//   pend_full     : per-channel pending counter saturated
//   arb_req/gnt   : request vector to arbiter, one-hot grant pulse back
//   arb_ack       : one-cycle pulse when a granted job finishes (or a bad grant is released)
//   beat_*        : downstream beat stream; beat_ready is the sink's accept
//   busy          : FSM not idle
//   err_ovf       : sticky, an enq was dropped on a full counter
//   err_proto     : sticky, a grant was malformed or arrived while running
//   dbg_state     : current FSM state
// Beat handshake: a beat transfers on any rising edge where beat_valid and
// beat_ready are both high; while beat_valid is high and beat_ready is low,
// beat_valid, beat_ch and beat_last hold their values.
module coreaxi4dma_arb_requester
  import coreaxi4dma_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          enq,
  input  logic [NUM_CH*LEN_W-1:0]    len,
  output logic [NUM_CH-1:0]          pend_full,
  output logic [NUM_CH-1:0]          arb_req,
  input  logic [NUM_CH-1:0]          arb_gnt,
  output logic                       arb_ack,
  output logic                       beat_valid,
  output logic [clog2(NUM_CH)-1:0]   beat_ch,
  output logic                       beat_last,
  input  logic                       beat_ready,
  output logic                       busy,
  output logic                       err_ovf,
  output logic                       err_proto,
  output logic [1:0]                 dbg_state
);

  localparam int CH_W = clog2(NUM_CH);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LEN_W-1:0]  beats_q, beats_d;

  logic [NUM_CH-1:0] nz, full, inc, dec;
  logic              gnt_any, gnt_ok, can_grant, accept;
  logic [CH_W-1:0]   gnt_idx;
  logic [LEN_W-1:0]  len_sel;

  // A grant is usable only if it is one-hot and names a channel with work.
  assign gnt_any   = |arb_gnt;
  assign gnt_ok    = is_onehot(32'(arb_gnt)) && ((arb_gnt & nz) != '0);
  assign gnt_idx   = CH_W'(onehot_encode(32'(arb_gnt)));
  assign can_grant = (state_q == IDLE) || (state_q == ACK);
  assign accept    = can_grant && gnt_ok;
  assign len_sel   = len[gnt_idx*LEN_W +: LEN_W];

  // A decrement in the same cycle frees a slot, so a simultaneous enq on a
  // full counter is kept (net count unchanged) rather than dropped.
  assign dec = accept ? arb_gnt : '0;
  assign inc = enq & (~full | dec);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pend
    coreaxi4dma_pend_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clock  (clock),
      .resetn (resetn),
      .inc    (inc[i]),
      .dec    (dec[i]),
      .cnt    (),
      .nz     (nz[i]),
      .full   (full[i])
    );
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    beats_d = beats_q;
    case (state_q)
      IDLE, ACK: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          ch_d    = gnt_idx;
          beats_d = len_sel;
        end else if (gnt_any) begin
          // Bad grant: no beats, but ack anyway so the arbiter is released.
          state_d = ACK;
        end
      end
      RUN: begin
        if (beat_ready) begin
          if (beats_q == '0) state_d = ACK;
          else               beats_d = beats_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      beats_q   <= '0;
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      beats_q <= beats_d;
      if (|(enq & ~inc)) err_ovf <= 1'b1;
      if (gnt_any && ((state_q == RUN) || (can_grant && !gnt_ok))) err_proto <= 1'b1;
    end
  end

  assign arb_req    = nz;
  assign pend_full  = full;
  assign beat_valid = (state_q == RUN);
  assign beat_last  = (state_q == RUN) && (beats_q == '0);
  assign beat_ch    = ch_q;
  assign arb_ack    = (state_q == ACK);
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_coreaxi4dma_arb_requester.sv
module tb_coreaxi4dma_arb_requester;

  logic        clock;
  logic        resetn;
  logic [3:0]  enq;
  logic [31:0] len;
  logic [3:0]  pend_full;
  logic [3:0]  arb_req;
  logic [3:0]  arb_gnt;
  logic        arb_ack;
  logic        beat_valid;
  logic [1:0]  beat_ch;
  logic        beat_last;
  logic        beat_ready;
  logic        busy;
  logic        err_ovf;
  logic        err_proto;
  logic [1:0]  dbg_state;

  coreaxi4dma_arb_requester #(.NUM_CH(4), .LEN_W(8), .CNT_W(3)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .enq        (enq),
    .len        (len),
    .pend_full  (pend_full),
    .arb_req    (arb_req),
    .arb_gnt    (arb_gnt),
    .arb_ack    (arb_ack),
    .beat_valid (beat_valid),
    .beat_ch    (beat_ch),
    .beat_last  (beat_last),
    .beat_ready (beat_ready),
    .busy       (busy),
    .err_ovf    (err_ovf),
    .err_proto  (err_proto),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] outs();
    return {arb_req, pend_full, beat_valid, beat_ch, beat_last, arb_ack, busy, err_proto, err_ovf};
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] req, input logic [3:0] fl, input logic v,
                                     input logic [1:0] ch, input logic l, input logic a,
                                     input logic b, input logic p, input logic o);
    return {req, fl, v, ch, l, a, b, p, o};
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    enq = '0;
    arb_gnt = '0;
    beat_ready = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // table-driven vectors
  typedef struct {
    logic [3:0]  enq;
    logic [3:0]  gnt;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [3:0] e, input logic [3:0] g, input logic [15:0] x);
    vec_t v;
    v.enq = e;
    v.gnt = g;
    v.exp = x;
    vecs.push_back(v);
  endtask

  // reference model and scoreboard for the random phase
  int         pend_m[4];
  bit         waiting;
  bit         ovf_m;
  int         grants;
  int         acks_seen;
  logic [2:0] exp_q[$];   // {channel, last}

  task automatic cycle_rand(input bit stim);
    logic [3:0] req_m, full_m, enq_v, gnt_v;
    logic [2:0] got, want;
    int st, lv, gc;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      req_m[i]  = (pend_m[i] != 0);
      full_m[i] = (pend_m[i] == 7);
    end
    chk("rand_arb_req", 32'(arb_req), 32'(req_m));
    chk("rand_pend_full", 32'(pend_full), 32'(full_m));
    if (arb_ack) acks_seen++;

    beat_ready = stim ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq_v[i] = stim && ($urandom_range(0, 4) == 0);
      len[i*8 +: 8] = 8'($urandom_range(0, 3));
    end
    gnt_v = '0;
    gc = 0;
    if (stim && (!waiting || arb_ack) && ($urandom_range(0, 1) == 1)) begin
      st = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) begin
        if (gnt_v == '0 && pend_m[(st + j) % 4] > 0) begin
          gnt_v[(st + j) % 4] = 1'b1;
          gc = (st + j) % 4;
        end
      end
    end
    enq = enq_v;
    arb_gnt = gnt_v;

    if (beat_valid && beat_ready) begin
      got = {beat_ch, beat_last};
      if (exp_q.size() == 0) begin
        chk("rand_unexpected_beat", 32'(got), 32'h7ff);
      end else begin
        want = exp_q.pop_front();
        chk("rand_beat", 32'(got), 32'(want));
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (enq_v[i]) begin
        if (pend_m[i] < 7 || gnt_v[i]) pend_m[i]++;
        else ovf_m = 1'b1;
      end
      if (gnt_v[i]) pend_m[i]--;
    end
    if (gnt_v != '0) begin
      lv = int'(len[gc*8 +: 8]);
      for (int b = 0; b <= lv; b++) exp_q.push_back({2'(gc), (b == lv)});
      grants++;
      waiting = 1'b1;
    end else if (arb_ack) begin
      waiting = 1'b0;
    end
  endtask

  logic [3:0] snap;
  int         acc;
  int         acks2;
  bit         found;
  logic       pat[4];

  initial begin
    resetn = 1'b0;
    enq = '0;
    len = '0;
    arb_gnt = '0;
    beat_ready = 1'b0;
    #1;
    chk("reset_async_outs", 32'(outs()), 32'h0);
    do_reset();
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);

    // single job, bad grants, counter saturation
    len = {8'd0, 8'd3, 8'd0, 8'd0};
    beat_ready = 1'b1;
    add(4'b0100, 4'b0000, mk(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    add(4'b0000, 4'b0100, mk(4'b0000, 4'b0000, 1, 2, 0, 0, 1, 0, 0));
    add(4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 1, 2, 0, 0, 1, 0, 0));
    add(4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 1, 2, 0, 0, 1, 0, 0));
    add(4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 1, 2, 1, 0, 1, 0, 0));
    add(4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 0, 2, 0, 1, 1, 0, 0));
    add(4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 0, 2, 0, 0, 0, 0, 0));
    add(4'b0000, 4'b0011, mk(4'b0000, 4'b0000, 0, 2, 0, 1, 1, 1, 0));
    add(4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 0, 2, 0, 0, 0, 1, 0));
    add(4'b0000, 4'b1000, mk(4'b0000, 4'b0000, 0, 2, 0, 1, 1, 1, 0));
    add(4'b0000, 4'b0000, mk(4'b0000, 4'b0000, 0, 2, 0, 0, 0, 1, 0));
    for (int k = 0; k < 6; k++)
      add(4'b1000, 4'b0000, mk(4'b1000, 4'b0000, 0, 2, 0, 0, 0, 1, 0));
    add(4'b1000, 4'b0000, mk(4'b1000, 4'b1000, 0, 2, 0, 0, 0, 1, 0));
    add(4'b1000, 4'b0000, mk(4'b1000, 4'b1000, 0, 2, 0, 0, 0, 1, 1));
    add(4'b1000, 4'b1000, mk(4'b1000, 4'b1000, 1, 3, 1, 0, 1, 1, 1));
    add(4'b0000, 4'b0000, mk(4'b1000, 4'b1000, 0, 3, 0, 1, 1, 1, 1));
    add(4'b0000, 4'b0000, mk(4'b1000, 4'b1000, 0, 3, 0, 0, 0, 1, 1));
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clock);
      enq = vecs[k].enq;
      arb_gnt = vecs[k].gnt;
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d", k), 32'(outs()), 32'(vecs[k].exp));
    end

    // grant during ACK: back-to-back jobs with no idle gap
    do_reset();
    len = {8'd0, 8'd0, 8'd0, 8'd1};
    beat_ready = 1'b1;
    enq = 4'b0011;
    @(negedge clock);
    enq = '0;
    chk("b2b_req", 32'(arb_req), 32'h3);
    arb_gnt = 4'b0001;
    @(negedge clock);
    arb_gnt = '0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clock);
      if (arb_ack) begin
        found = 1'b1;
        arb_gnt = 4'b0010;
      end
    end
    chk("b2b_first_ack", 32'(found), 32'h1);
    @(negedge clock);
    arb_gnt = '0;
    chk("b2b_run_ch1", 32'({beat_valid, beat_ch, beat_last, arb_ack, busy}), 32'({1'b1, 2'd1, 1'b1, 1'b0, 1'b1}));
    acks2 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (arb_ack) acks2++;
    end
    chk("b2b_single_ack", 32'(acks2), 32'h1);
    chk("b2b_idle", 32'({busy, arb_req}), 32'h0);

    // beat_ready stalls on a two-beat job
    do_reset();
    len = {8'd0, 8'd0, 8'd0, 8'd1};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    enq = 4'b0001;
    @(negedge clock);
    enq = '0;
    arb_gnt = 4'b0001;
    @(negedge clock);
    arb_gnt = '0;
    acc = 0;
    snap = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      beat_ready = pat[k];
      chk($sformatf("stall_valid%0d", k), 32'(beat_valid), 32'h1);
      chk($sformatf("stall_last%0d", k), 32'(beat_last), 32'(k != 0));
      if (k >= 2) chk($sformatf("stall_hold%0d", k), 32'({beat_valid, beat_ch, beat_last}), 32'(snap));
      snap = {beat_valid, beat_ch, beat_last};
      if (beat_valid && beat_ready) acc++;
    end
    @(negedge clock);
    chk("stall_ack", 32'({arb_ack, beat_valid}), 32'h2);
    chk("stall_accepted", 32'(acc), 32'h2);
    @(negedge clock);
    chk("stall_idle", 32'(busy), 32'h0);

    // asynchronous reset in the middle of a long job
    do_reset();
    len = {8'd0, 8'd0, 8'd0, 8'd7};
    beat_ready = 1'b1;
    enq = 4'b0011;
    @(negedge clock);
    enq = 4'b0001;
    arb_gnt = 4'b0001;
    @(negedge clock);
    enq = '0;
    arb_gnt = '0;
    @(negedge clock);
    chk("mid_job_running", 32'({beat_valid, arb_req}), 32'h13);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_job_async_reset", 32'(outs()), 32'h0);
    chk("mid_job_state", 32'(dbg_state), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_job_after_release", 32'({arb_req, busy, beat_valid}), 32'h0);

    // randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 4; i++) pend_m[i] = 0;
    waiting = 1'b0;
    ovf_m = 1'b0;
    grants = 0;
    acks_seen = 0;
    exp_q.delete();
    for (int c = 0; c < 2000; c++) cycle_rand(1'b1);
    for (int c = 0; c < 300 && (waiting || exp_q.size() != 0 || busy); c++) cycle_rand(1'b0);
    chk("rand_drained", 32'({waiting, busy}), 32'h0);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("rand_acks", 32'(acks_seen), 32'(grants));
    chk("rand_err_ovf", 32'(err_ovf), 32'(ovf_m));
    chk("rand_err_proto", 32'(err_proto), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
